// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, addresses the instruction ROM and
// registers the returned word into the IF/ID pipeline register.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0080,
  parameter logic [31:0] NOP        = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        exc_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic        misalign_fault,
  output logic [31:0] fault_addr,
  output logic [31:0] fetch_count
);

  logic [31:0] pc_q, pc_d, instr_q, instr_d, ipc_q, ipc_d, ip4_q, ip4_d;
  logic [31:0] faddr_q, faddr_d, cnt_q, cnt_d;
  logic        vld_q, vld_d, flt_q, flt_d;
  logic        redirect, ctl_xfer, misalign;
  logic [31:0] tgt, pc_inc;

  assign pc_inc   = pc_q + 32'd4;
  assign ctl_xfer = branch_taken | jump;
  assign redirect = exc_req | ctl_xfer;
  assign tgt      = branch_taken ? branch_target : jump_target;
  // Exceptions outrank control transfers, so a masked target never faults.
  assign misalign = !exc_req && ctl_xfer && (tgt[1:0] != 2'b00);

  always_comb begin
    pc_d    = pc_inc;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    ip4_d   = ip4_q;
    vld_d   = vld_q;
    cnt_d   = cnt_q;
    flt_d   = misalign;
    faddr_d = misalign ? tgt : faddr_q;
    if (exc_req || misalign) pc_d = EXC_VECTOR;
    else if (ctl_xfer)       pc_d = tgt;
    else if (stall)          pc_d = pc_q;

    // Squash drops the wrong-path word; IF/ID PC fields keep their last value.
    if (redirect) begin
      instr_d = NOP;
      vld_d   = 1'b0;
    end else if (!stall) begin
      instr_d = imem_data;
      ipc_d   = pc_q;
      ip4_d   = pc_inc;
      vld_d   = 1'b1;
      cnt_d   = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      instr_q <= NOP;
      ipc_q   <= '0;
      ip4_q   <= '0;
      vld_q   <= 1'b0;
      flt_q   <= 1'b0;
      faddr_q <= '0;
      cnt_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      ip4_q   <= ip4_d;
      vld_q   <= vld_d;
      flt_q   <= flt_d;
      faddr_q <= faddr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign imem_addr      = pc_q;
  assign pc             = pc_q;
  assign if_id_instr    = instr_q;
  assign if_id_pc       = ipc_q;
  assign if_id_pc_plus4 = ip4_q;
  assign if_id_valid    = vld_q;
  assign misalign_fault = flt_q;
  assign fault_addr     = faddr_q;
  assign fetch_count    = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Table-driven bench for fetch_unit; a second instance covers PC wrap-around.
module tb_fetch_unit;

  logic        clock = 1'b0;
  logic        reset, stall, branch_taken, jump, exc_req;
  logic [31:0] branch_target, jump_target;

  logic [31:0] a1, d1, pc1, ins1, ipc1, ip41, fa1, cnt1;
  logic        v1, f1;
  logic [31:0] a2, d2, pc2, ins2, ipc2, ip42, fa2, cnt2;
  logic        v2, f2;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  function automatic logic [31:0] rom(input logic [31:0] a);
    if (a < 32'd16) begin
      case (a[3:2])
        2'd0: return 32'h11;
        2'd1: return 32'h22;
        2'd2: return 32'h33;
        default: return 32'h44;
      endcase
    end
    return 32'hA000_0000 | a;
  endfunction

  assign d1 = rom(a1);
  assign d2 = rom(a2);

  fetch_unit dut (
    .clock(clock), .reset(reset), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target), .exc_req(exc_req),
    .imem_addr(a1), .imem_data(d1), .pc(pc1), .if_id_instr(ins1),
    .if_id_pc(ipc1), .if_id_pc_plus4(ip41), .if_id_valid(v1),
    .misalign_fault(f1), .fault_addr(fa1), .fetch_count(cnt1)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clock(clock), .reset(reset), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target), .exc_req(exc_req),
    .imem_addr(a2), .imem_data(d2), .pc(pc2), .if_id_instr(ins2),
    .if_id_pc(ipc2), .if_id_pc_plus4(ip42), .if_id_valid(v2),
    .misalign_fault(f2), .fault_addr(fa2), .fetch_count(cnt2)
  );

  typedef struct {
    logic        rst, stl, br;
    logic [31:0] bt;
    logic        jmp;
    logic [31:0] jt;
    logic        exc;
    logic [31:0] e_pc, e_ins, e_ipc, e_p4;
    logic        e_v, e_flt;
    logic [31:0] e_fa, e_cnt;
  } vec_t;

  vec_t vt[19];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, s, b, input logic [31:0] bt,
                       input logic j, input logic [31:0] jt, input logic e);
    reset = r; stall = s; branch_taken = b; branch_target = bt;
    jump = j; jump_target = jt; exc_req = e;
    @(posedge clock);
    #1;
  endtask

  initial begin
    //          rst  stl  br   bt          jmp  jt          exc  pc          ins           ipc         p4          v    flt  fa          cnt
    vt[0]  = '{1'b1,1'b0,1'b0,32'h0,      1'b0,32'h0,      1'b0,32'h0,      32'h0,        32'h0,      32'h0,      1'b0,1'b0,32'h0,      32'd0};
    vt[1]  = '{1'b0,1'b0,1'b0,32'h0,      1'b0,32'h0,      1'b0,32'h4,      32'h11,       32'h0,      32'h4,      1'b1,1'b0,32'h0,      32'd1};
    vt[2]  = '{1'b0,1'b0,1'b0,32'h0,      1'b0,32'h0,      1'b0,32'h8,      32'h22,       32'h4,      32'h8,      1'b1,1'b0,32'h0,      32'd2};
    vt[3]  = '{1'b0,1'b1,1'b0,32'h0,      1'b0,32'h0,      1'b0,32'h8,      32'h22,       32'h4,      32'h8,      1'b1,1'b0,32'h0,      32'd2};
    vt[4]  = '{1'b0,1'b1,1'b0,32'h0,      1'b0,32'h0,      1'b0,32'h8,      32'h22,       32'h4,      32'h8,      1'b1,1'b0,32'h0,      32'd2};
    vt[5]  = '{1'b0,1'b0,1'b0,32'h0,      1'b0,32'h0,      1'b0,32'hC,      32'h33,       32'h8,      32'hC,      1'b1,1'b0,32'h0,      32'd3};
    vt[6]  = '{1'b0,1'b0,1'b0,32'h0,      1'b0,32'h0,      1'b0,32'h10,     32'h44,       32'hC,      32'h10,     1'b1,1'b0,32'h0,      32'd4};
    vt[7]  = '{1'b0,1'b0,1'b1,32'h40,     1'b0,32'h0,      1'b0,32'h40,     32'h0,        32'hC,      32'h10,     1'b0,1'b0,32'h0,      32'd4};
    vt[8]  = '{1'b0,1'b0,1'b0,32'h0,      1'b0,32'h0,      1'b0,32'h44,     32'hA000_0040,32'h40,     32'h44,     1'b1,1'b0,32'h0,      32'd5};
    vt[9]  = '{1'b0,1'b1,1'b1,32'h41,     1'b1,32'h42,     1'b1,32'h80,     32'h0,        32'h40,     32'h44,     1'b0,1'b0,32'h0,      32'd5};
    vt[10] = '{1'b0,1'b0,1'b0,32'h0,      1'b0,32'h0,      1'b0,32'h84,     32'hA000_0080,32'h80,     32'h84,     1'b1,1'b0,32'h0,      32'd6};
    vt[11] = '{1'b0,1'b0,1'b0,32'h0,      1'b1,32'h42,     1'b0,32'h80,     32'h0,        32'h80,     32'h84,     1'b0,1'b1,32'h42,     32'd6};
    vt[12] = '{1'b0,1'b0,1'b0,32'h0,      1'b0,32'h0,      1'b0,32'h84,     32'hA000_0080,32'h80,     32'h84,     1'b1,1'b0,32'h42,     32'd7};
    vt[13] = '{1'b0,1'b0,1'b0,32'h0,      1'b1,32'h200,    1'b0,32'h200,    32'h0,        32'h80,     32'h84,     1'b0,1'b0,32'h42,     32'd7};
    vt[14] = '{1'b0,1'b0,1'b1,32'h300,    1'b0,32'h0,      1'b0,32'h300,    32'h0,        32'h80,     32'h84,     1'b0,1'b0,32'h42,     32'd7};
    vt[15] = '{1'b0,1'b1,1'b1,32'h301,    1'b0,32'h0,      1'b0,32'h80,     32'h0,        32'h80,     32'h84,     1'b0,1'b1,32'h301,    32'd7};
    vt[16] = '{1'b0,1'b1,1'b0,32'h0,      1'b0,32'h0,      1'b0,32'h80,     32'h0,        32'h80,     32'h84,     1'b0,1'b0,32'h301,    32'd7};
    vt[17] = '{1'b0,1'b0,1'b0,32'h0,      1'b0,32'h0,      1'b0,32'h84,     32'hA000_0080,32'h80,     32'h84,     1'b1,1'b0,32'h301,    32'd8};
    vt[18] = '{1'b1,1'b0,1'b0,32'h0,      1'b0,32'h0,      1'b0,32'h0,      32'h0,        32'h0,      32'h0,      1'b0,1'b0,32'h0,      32'd0};

    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 19; i++) begin
      drive(vt[i].rst, vt[i].stl, vt[i].br, vt[i].bt, vt[i].jmp, vt[i].jt, vt[i].exc);
      chk($sformatf("v%0d.pc", i),    pc1,  vt[i].e_pc);
      chk($sformatf("v%0d.addr", i),  a1,   vt[i].e_pc);
      chk($sformatf("v%0d.instr", i), ins1, vt[i].e_ins);
      chk($sformatf("v%0d.ifpc", i),  ipc1, vt[i].e_ipc);
      chk($sformatf("v%0d.pc4", i),   ip41, vt[i].e_p4);
      chk($sformatf("v%0d.valid", i), {31'b0, v1}, {31'b0, vt[i].e_v});
      chk($sformatf("v%0d.fault", i), {31'b0, f1}, {31'b0, vt[i].e_flt});
      chk($sformatf("v%0d.faddr", i), fa1,  vt[i].e_fa);
      chk($sformatf("v%0d.count", i), cnt1, vt[i].e_cnt);
    end

    // Wrap-around from 0xFFFFFFFC, then reset mid-run.
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk("wrap.rst_pc", pc2, 32'hFFFF_FFFC);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk("wrap.pc",    pc2,  32'h0);
    chk("wrap.ifpc",  ipc2, 32'hFFFF_FFFC);
    chk("wrap.pc4",   ip42, 32'h0);
    chk("wrap.instr", ins2, 32'hFFFF_FFFC);
    chk("wrap.valid", {31'b0, v2}, 32'd1);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk("wrap.pc2",   pc2,  32'h4);
    chk("wrap.count", cnt2, 32'd2);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk("midrst.pc",    pc2,  32'hFFFF_FFFC);
    chk("midrst.valid", {31'b0, v2}, 32'd0);
    chk("midrst.count", cnt2, 32'd0);
    chk("midrst.instr", ins2, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
